// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store sequencer sitting between the EX/MEM pipeline register and a
// 64-bit wide data memory (one entry per 8-byte-aligned address). It accepts
// one request at a time, runs the memory access and returns exactly one
// response pulse per request.
//
//   * Loads   : read the entry, extract the size-wide field at the byte
//               offset, then zero- or sign-extend it to 64 bits.
//   * Stores  : dword stores write the entry directly; byte/half/word stores
//               are read-modify-write (read old entry, merge field, write).
//   * Layout  : little-endian, byte k of an entry is bits [8k+7:8k].
//
// Build option:
//   MAU_ALIGN_CHECK_EN  defined   -> a request whose byte offset is not a
//                                    multiple of its size is rejected with
//                                    misalign_err=1, no memory strobes.
//                       undefined -> misalign_err is tied 0; the offset is
//                                    rounded down to the size alignment and
//                                    the access proceeds normally.
//
// Ports:
//   CLOCK        in   single clock, all state updates on posedge
//   RESET        in   synchronous active-high reset
//   req_valid    in   request present
//   req_ready    out  unit idle; accept on req_valid && req_ready at posedge
//   req_write    in   1 = store, 0 = load
//   req_size     in   00 byte, 01 half, 10 word, 11 dword
//   req_signed   in   loads: 1 sign-extend, 0 zero-extend (ignored for dword)
//   req_addr     in   byte address
//   req_wdata    in   store data, right-justified
//   resp_valid   out  one-cycle response pulse, no backpressure
//   resp_rdata   out  extended load data; 0 for stores and errors
//   misalign_err out  qualified by resp_valid; request was misaligned
//   mem_address  out  entry address {req_addr[63:3], 3'b000}
//   mem_wdata    out  full 64-bit write data (merged for RMW)
//   mem_read     out  memory read strobe
//   mem_write    out  memory write strobe
//   mem_rdata    in   memory read data (memory updates it on negedge)
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } stateT;

  stateT             state;

  // Fields latched at acceptance; memory-side outputs depend only on these
  // and on the state, never on the live request inputs.
  logic [ADDR_W-1:0] addrReg;
  logic [1:0]        sizeReg;
  logic              signedReg;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] entryReg;      // old entry captured during RMW_RD

  logic              respValidReg;
  logic [DATA_W-1:0] respRdataReg;
  logic              reqMisaligned;
  logic [2:0]        effOffset;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Clears the low log2(size) offset bits. For an aligned offset this is the
  // identity, so it doubles as the misalignment test and the rounding rule.
  function automatic logic [2:0] alignedOffset(input logic [2:0] offset,
                                               input logic [1:0] size);
    case (size)
      2'b00:   alignedOffset = offset;
      2'b01:   alignedOffset = {offset[2:1], 1'b0};
      2'b10:   alignedOffset = {offset[2], 2'b00};
      default: alignedOffset = 3'b000;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] fieldMask(input logic [1:0] size);
    case (size)
      2'b00:   fieldMask = 64'h0000_0000_0000_00FF;
      2'b01:   fieldMask = 64'h0000_0000_0000_FFFF;
      2'b10:   fieldMask = 64'h0000_0000_FFFF_FFFF;
      default: fieldMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Shift the addressed field down to bit 0, then extend it.
  function automatic logic [DATA_W-1:0] extendField(input logic [DATA_W-1:0] entry,
                                                    input logic [2:0]        offset,
                                                    input logic [1:0]        size,
                                                    input logic              isSigned);
    logic [DATA_W-1:0] shifted;
    shifted = entry >> {offset, 3'b000};
    case (size)
      2'b00:   extendField = {{56{isSigned & shifted[7]}},  shifted[7:0]};
      2'b01:   extendField = {{48{isSigned & shifted[15]}}, shifted[15:0]};
      2'b10:   extendField = {{32{isSigned & shifted[31]}}, shifted[31:0]};
      default: extendField = shifted;
    endcase
  endfunction

  // Replace the size-wide field at the offset, keep every other byte.
  function automatic logic [DATA_W-1:0] mergeField(input logic [DATA_W-1:0] oldEntry,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [2:0]        offset,
                                                   input logic [1:0]        size);
    logic [DATA_W-1:0] laneMask;
    laneMask   = fieldMask(size) << {offset, 3'b000};
    mergeField = (oldEntry & ~laneMask) |
                 ((wdata & fieldMask(size)) << {offset, 3'b000});
  endfunction

  // ---------------------------------------------------------------------------
  // Alignment handling
  // ---------------------------------------------------------------------------
`ifdef MAU_ALIGN_CHECK_EN
  assign reqMisaligned = (alignedOffset(req_addr[2:0], req_size) != req_addr[2:0]);
`else
  assign reqMisaligned = 1'b0;
`endif

  // Misaligned requests never reach the datapath when checking is enabled,
  // so the rounded offset is correct in both builds.
  assign effOffset = alignedOffset(addrReg[2:0], sizeReg);

  // ---------------------------------------------------------------------------
  // Control FSM with registered response outputs
  // ---------------------------------------------------------------------------
`ifdef MAU_ALIGN_CHECK_EN
  logic misalignReg;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= IDLE;
      respValidReg <= 1'b0;
      respRdataReg <= '0;
`ifdef MAU_ALIGN_CHECK_EN
      misalignReg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          respValidReg <= 1'b0;
          respRdataReg <= '0;
          if (req_valid) begin
            if (reqMisaligned) begin
              // Rejected without touching memory; respond next cycle.
              state        <= RESP;
              respValidReg <= 1'b1;
`ifdef MAU_ALIGN_CHECK_EN
              misalignReg  <= 1'b1;
`endif
            end else if (!req_write) begin
              state <= RD;
            end else if (req_size == 2'b11) begin
              state <= WR;
            end else begin
              state <= RMW_RD;
            end
          end
        end

        RD: begin
          respRdataReg <= extendField(mem_rdata, effOffset, sizeReg, signedReg);
          respValidReg <= 1'b1;
          state        <= RESP;
        end

        WR: begin
          respValidReg <= 1'b1;
          state        <= RESP;
        end

        RMW_RD: begin
          state <= RMW_WR;
        end

        RMW_WR: begin
          respValidReg <= 1'b1;
          state        <= RESP;
        end

        RESP: begin
          respValidReg <= 1'b0;
          respRdataReg <= '0;
`ifdef MAU_ALIGN_CHECK_EN
          misalignReg  <= 1'b0;
`endif
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath capture
  // ---------------------------------------------------------------------------
  // NOTE: pure datapath registers are not reset; they are always written
  // before use, and control state alone decides when they are meaningful.
  always_ff @(posedge CLOCK) begin
    if (state == IDLE && req_valid) begin
      addrReg   <= req_addr;
      sizeReg   <= req_size;
      signedReg <= req_signed;
      wdataReg  <= req_wdata;
    end
    if (state == RMW_RD) begin
      entryReg <= mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side decode (state + latched fields only)
  // ---------------------------------------------------------------------------
  assign mem_address = {addrReg[ADDR_W-1:3], 3'b000};

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output
    // unassigned, which would otherwise infer a latch.
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state)
      RD, RMW_RD: mem_read = 1'b1;
      WR: begin
        mem_write = 1'b1;
        mem_wdata = wdataReg;
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_wdata = mergeField(entryReg, wdataReg, effOffset, sizeReg);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request/response side
  // ---------------------------------------------------------------------------
  assign req_ready  = (state == IDLE);
  assign resp_valid = respValidReg;
  assign resp_rdata = respRdataReg;

`ifdef MAU_ALIGN_CHECK_EN
  assign misalign_err = misalignReg;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

`ifdef MAU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        misalign_err;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          lat;
    logic [63:0] rd;
    logic        err;
    logic        sawRd;
    logic        sawWr;
    logic        addrOk;
  } txnResT;

  mem_access_unit dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  always #5 CLOCK = ~CLOCK;

  // Data memory: 32 entries (byte addresses 0..255), writes at posedge,
  // read data refreshed on negedge. Backdoor port used only while idle.
  logic [63:0] memArr [32];
  logic [63:0] refMem [32];
  logic        bdEn = 1'b0;
  logic [4:0]  bdIdx = '0;
  logic [63:0] bdData = '0;

  always @(posedge CLOCK) begin
    if (mem_write) memArr[mem_address[7:3]] <= mem_wdata;
    else if (bdEn) memArr[bdIdx] <= bdData;
  end

  always @(negedge CLOCK) mem_rdata <= memArr[mem_address[7:3]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain byte arithmetic on whole entries
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] sizeMask(input int nbytes);
    if (nbytes == 8) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << (8 * nbytes)) - 64'd1;
  endfunction

  function automatic logic [63:0] refLoad(input logic [63:0] entry, input int nbytes,
                                          input int off, input logic sg);
    logic [63:0] v;
    v = (entry >> (8 * off)) & sizeMask(nbytes);
    if (sg && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~sizeMask(nbytes);
    return v;
  endfunction

  function automatic logic [63:0] refStore(input logic [63:0] entry, input logic [63:0] wd,
                                           input int nbytes, input int off);
    return (entry & ~(sizeMask(nbytes) << (8 * off))) |
           ((wd & sizeMask(nbytes)) << (8 * off));
  endfunction

  function automatic int memDiffs();
    int n = 0;
    for (int i = 0; i < 32; i++) if (memArr[i] !== refMem[i]) n++;
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers (all called at #1 after a posedge)
  // ---------------------------------------------------------------------------
  task automatic bdWrite(input int idx, input logic [63:0] data);
    bdEn = 1'b1; bdIdx = 5'(idx); bdData = data;
    @(posedge CLOCK); #1;
    bdEn = 1'b0;
    refMem[idx] = data;
  endtask

  // Presents a request and returns at #1 after the accept edge (cycle 1).
  task automatic startReq(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [63:0] a, input logic [63:0] wd, output logic ok);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    ok = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge CLOCK); #1;
    end
    if (ok) begin @(posedge CLOCK); #1; end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: req_ready=%b after 20 cycles, required 1", req_ready);
    end
  endtask

  // Full transaction. While busy a junk dword store is held on the request
  // port; it must be ignored and is dropped in the response cycle.
  task automatic doTxn(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd, output txnResT r);
    logic ok;
    r.lat = -1; r.rd = '0; r.err = 1'b0; r.sawRd = 1'b0; r.sawWr = 1'b0; r.addrOk = 1'b1;
    startReq(w, sz, sg, a, wd, ok);
    if (!ok) return;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11;
    req_addr = 64'($urandom_range(0, 255)); req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= 8; c++) begin
      if (mem_read)  r.sawRd = 1'b1;
      if (mem_write) r.sawWr = 1'b1;
      if ((mem_read || mem_write) && mem_address !== {a[63:3], 3'b000}) r.addrOk = 1'b0;
      if (resp_valid) begin
        r.lat = c; r.rd = resp_rdata; r.err = misalign_err;
        break;
      end
      @(posedge CLOCK); #1;
    end
    req_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // RESET still high here; outputs must show the reset state.
    checks++; if (req_ready !== 1'b1)    begin failures++; $display("FAIL rst_ready: got %b, required 1", req_ready); end
    checks++; if (resp_valid !== 1'b0)   begin failures++; $display("FAIL rst_resp_valid: got %b, required 0", resp_valid); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_misalign: got %b, required 0", misalign_err); end
    checks++; if (resp_rdata !== 64'd0)  begin failures++; $display("FAIL rst_rdata: got %h, required 0", resp_rdata); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      failures++; $display("FAIL rst_strobes: got rd=%b wr=%b, required 0 0", mem_read, mem_write);
    end
    RESET = 1'b0;
    @(posedge CLOCK); #1;
  endtask

  task automatic test_spec_examples();
    txnResT r;
    logic [63:0] expRd;
    int expLat;
    logic expErr;
    bdWrite(2, 64'd2);
    doTxn(1'b0, 2'b11, 1'b0, 64'd16, 64'd0, r);
    checks++; if (r.lat !== 2)      begin failures++; $display("FAIL ld_dword_lat: got %0d, required 2", r.lat); end
    checks++; if (r.rd !== 64'd2)   begin failures++; $display("FAIL ld_dword_data: got %h, required 2", r.rd); end

    doTxn(1'b1, 2'b00, 1'b0, 64'd17, 64'h1234_5678_9ABC_DEAB, r);
    refMem[2] = 64'h0000_0000_0000_AB02;
    checks++; if (r.lat !== 3)      begin failures++; $display("FAIL st_byte_lat: got %0d, required 3", r.lat); end
    checks++; if (memArr[2] !== 64'h0000_0000_0000_AB02) begin
      failures++; $display("FAIL st_byte_entry: got %h, required 000000000000ab02", memArr[2]);
    end
    checks++; if (r.rd !== 64'd0)   begin failures++; $display("FAIL st_byte_rdata: got %h, required 0", r.rd); end

    doTxn(1'b0, 2'b00, 1'b1, 64'd17, 64'd0, r);
    checks++; if (r.rd !== 64'hFFFF_FFFF_FFFF_FFAB) begin
      failures++; $display("FAIL ld_byte_signed: got %h, required ffffffffffffffab", r.rd);
    end
    doTxn(1'b0, 2'b00, 1'b0, 64'd17, 64'd0, r);
    checks++; if (r.rd !== 64'h0000_0000_0000_00AB) begin
      failures++; $display("FAIL ld_byte_unsigned: got %h, required 00000000000000ab", r.rd);
    end

    // Half load at 0x21: rejected with checking on, read at 0x20 otherwise.
    bdWrite(4, 64'h0123_4567_89AB_CDEF);
    expErr = ALIGN_CHECK;
    expLat = expErr ? 1 : 2;
    expRd  = expErr ? 64'd0 : 64'h0000_0000_0000_CDEF;
    doTxn(1'b0, 2'b01, 1'b0, 64'h21, 64'd0, r);
    checks++; if (r.lat !== expLat) begin failures++; $display("FAIL mis_half_lat: got %0d, required %0d", r.lat, expLat); end
    checks++; if (r.err !== expErr) begin failures++; $display("FAIL mis_half_err: got %b, required %b", r.err, expErr); end
    checks++; if (r.rd !== expRd)   begin failures++; $display("FAIL mis_half_data: got %h, required %h", r.rd, expRd); end
    checks++; if (r.sawRd !== !expErr) begin
      failures++; $display("FAIL mis_half_read: mem_read seen=%b, required %b", r.sawRd, !expErr);
    end
  endtask

  task automatic test_back_to_back();
    txnResT r;
    doTxn(1'b1, 2'b11, 1'b0, 64'd8, 64'h55, r);
    refMem[1] = 64'h55;
    checks++; if (r.lat !== 2) begin failures++; $display("FAIL b2b_store_lat: got %0d, required 2", r.lat); end
    doTxn(1'b0, 2'b11, 1'b0, 64'd8, 64'd0, r);
    checks++; if (r.lat !== 2)     begin failures++; $display("FAIL b2b_load_lat: got %0d, required 2", r.lat); end
    checks++; if (r.rd !== 64'h55) begin failures++; $display("FAIL b2b_load_data: got %h, required 55", r.rd); end
    checks++; if (memDiffs() != 0) begin failures++; $display("FAIL b2b_mem: got %0d differing entries, required 0", memDiffs()); end
  endtask

  task automatic test_reset_midflight();
    logic ok;
    int seen;
    // Reset while in RMW_RD: read discarded, memory untouched.
    startReq(1'b1, 2'b00, 1'b0, 64'd18, 64'h77, ok);
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_rmwrd_strobe: mem_read=%b, required 1", mem_read); end
    RESET = 1'b1; @(posedge CLOCK); #1; RESET = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_rmwrd_ready: got %b, required 1", req_ready); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) seen++;
      @(posedge CLOCK); #1;
    end
    checks++; if (seen != 0)       begin failures++; $display("FAIL rst_rmwrd_resp: got %0d pulses, required 0", seen); end
    checks++; if (memDiffs() != 0) begin failures++; $display("FAIL rst_rmwrd_mem: got %0d differing entries, required 0", memDiffs()); end

    // Reset while in RMW_WR: the write still lands, no response.
    startReq(1'b1, 2'b01, 1'b0, 64'h2A, 64'hBEEF, ok);
    @(posedge CLOCK); #1;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rst_rmwwr_strobe: mem_write=%b, required 1", mem_write); end
    RESET = 1'b1; @(posedge CLOCK); #1; RESET = 1'b0;
    refMem[5] = refStore(refMem[5], 64'hBEEF, 2, 2);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) seen++;
      @(posedge CLOCK); #1;
    end
    checks++; if (seen != 0)       begin failures++; $display("FAIL rst_rmwwr_resp: got %0d pulses, required 0", seen); end
    checks++; if (memDiffs() != 0) begin failures++; $display("FAIL rst_rmwwr_mem: got %0d differing entries, required 0", memDiffs()); end
  endtask

  task automatic test_random(input int n);
    txnResT r;
    for (int i = 0; i < n; i++) begin
      logic        w, sg, expErr, expRead, expWrite;
      logic [1:0]  sz;
      logic [63:0] a, wd, expRd;
      int          nb, off, eo, idx, expLat;
      w   = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      sg  = 1'($urandom_range(0, 1));
      a   = 64'($urandom_range(0, 255));
      wd  = {$urandom, $urandom};
      nb  = 1 << sz;
      off = int'(a[2:0]);
      idx = int'(a[7:3]);
      eo  = off - (off % nb);
      expErr = ALIGN_CHECK && ((off % nb) != 0);
      if (expErr) begin
        expLat = 1; expRd = '0;
      end else if (!w) begin
        expLat = 2; expRd = refLoad(refMem[idx], nb, eo, sg);
      end else begin
        expLat = (nb == 8) ? 2 : 3; expRd = '0;
        refMem[idx] = refStore(refMem[idx], wd, nb, eo);
      end
      expRead  = !expErr && (!w || nb < 8);
      expWrite = !expErr && w;
      doTxn(w, sz, sg, a, wd, r);
      checks++; if (r.lat !== expLat) begin
        failures++; $display("FAIL rnd%0d_lat: w=%b sz=%0d a=%h got %0d, required %0d", i, w, sz, a, r.lat, expLat);
      end
      checks++; if (r.rd !== expRd) begin
        failures++; $display("FAIL rnd%0d_data: w=%b sz=%0d sg=%b a=%h got %h, required %h", i, w, sz, sg, a, r.rd, expRd);
      end
      checks++; if (r.err !== expErr) begin
        failures++; $display("FAIL rnd%0d_err: got %b, required %b", i, r.err, expErr);
      end
      checks++; if (r.sawRd !== expRead || r.sawWr !== expWrite) begin
        failures++; $display("FAIL rnd%0d_strobes: got rd=%b wr=%b, required rd=%b wr=%b", i, r.sawRd, r.sawWr, expRead, expWrite);
      end
      checks++; if (r.addrOk !== 1'b1) begin
        failures++; $display("FAIL rnd%0d_addr: mem_address wrong during strobe, required %h", i, {a[63:3], 3'b000});
      end
      checks++; if (memDiffs() != 0) begin
        failures++; $display("FAIL rnd%0d_mem: got %0d differing entries, required 0", i, memDiffs());
      end
    end
  endtask

  initial begin
    @(posedge CLOCK); #1;
    for (int i = 0; i < 32; i++) bdWrite(i, {$urandom, $urandom});
    test_reset();
    test_spec_examples();
    test_back_to_back();
    test_reset_midflight();
    test_random(80);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
